val_rdy_skid_buffer: RTL and testbench



---
 rtl/val_rdy_skid_pkg.sv | 17 +
 rtl/val_rdy_skid_buffer_en_data_reg.sv | 21 ++
 rtl/val_rdy_skid_buffer.sv | 110 +++++++++++
 tb/tb_val_rdy_skid_buffer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/val_rdy_skid_pkg.sv
// Shared definitions for the val/rdy skid buffer: the control state
// encoding and the width of the state field.
package val_rdy_skid_pkg;

    localparam int unsigned STATE_W = 2;

    // Number of messages held: EMPTY = none, ONE = head only, FULL = head + skid.
    typedef enum logic [STATE_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // The one encoding the state register must never hold.
    localparam logic [STATE_W-1:0] STATE_ILLEGAL = 2'd3;

endpackage

// File: rtl/val_rdy_skid_buffer_en_data_reg.sv
// Enabled data register without reset. Used for the head (main) and the
// overflow (skid) storage of the skid buffer.
module en_data_reg #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               en,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);

    // Capture d when enabled, otherwise hold.
    // NOTE: data registers are deliberately not reset; only control state is,
    // because out_val already masks whatever stale value sits here.
    always_ff @(posedge clk) begin
        if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/val_rdy_skid_buffer.sv
// Two-entry val/rdy skid buffer. Registers both the data path and the ready
// path: in_rdy and out_val come only from registered state (and reset), so
// no combinational path runs from out_rdy to in_rdy. Sustains one message
// per cycle; absorbs exactly one extra message when the consumer stalls.
module val_rdy_skid_buffer
    import val_rdy_skid_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg
);

    state_t             state_q;
    logic               in_f;
    logic               out_f;
    logic               main_en;
    logic               skid_en;
    logic               main_sel_skid;
    logic [p_nbits-1:0] main_d;
    logic [p_nbits-1:0] main_q;
    logic [p_nbits-1:0] skid_q;

    // Handshake outputs depend only on registered state and reset.
    assign in_rdy  = !reset && (state_q != FULL);
    assign out_val = !reset && (state_q != EMPTY);

    assign in_f  = in_val  && in_rdy;
    assign out_f = out_val && out_rdy;

    // Register enables and head-input select derived from state and fires.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case can leave a latch behind.
        main_en       = 1'b0;
        skid_en       = 1'b0;
        main_sel_skid = (state_q == FULL);
        unique case (state_q)
            EMPTY: main_en = in_f;
            ONE: begin
                main_en = in_f && out_f;
                skid_en = in_f && !out_f;
            end
            FULL:    main_en = out_f;
            default: ;
        endcase
    end

    // Head refills from the skid register when draining from FULL.
    assign main_d = main_sel_skid ? skid_q : in_msg;

    // Control FSM: occupancy tracking with synchronous reset.
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (in_f) state_q <= ONE;
                ONE: begin
                    if (in_f && !out_f)      state_q <= FULL;
                    else if (!in_f && out_f) state_q <= EMPTY;
                end
                FULL:    if (out_f) state_q <= ONE;
                default: state_q <= EMPTY;
            endcase
        end
    end

    en_data_reg #(.p_nbits(p_nbits)) u_main_reg (
        .clk (clk),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    en_data_reg #(.p_nbits(p_nbits)) u_skid_reg (
        .clk (clk),
        .en  (skid_en),
        .d   (in_msg),
        .q   (skid_q)
    );

    assign out_msg = main_q;

`ifndef SYNTHESIS
    logic [STATE_W-1:0] state_bits;
    assign state_bits = state_q;

    // Handshake controls from neighbours must be known outside reset.
    a_ctrl_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown({in_val, out_rdy}));

    // The unused state encoding must never be reached.
    a_state_legal: assert property (@(posedge clk) disable iff (reset)
        state_bits != STATE_ILLEGAL);

    // A producer that is stalled must keep offering the same message.
    a_in_hold: assert property (@(posedge clk) disable iff (reset)
        (in_val && !in_rdy) |=> (in_val && $stable(in_msg)));
`endif

endmodule

// File: tb/tb_val_rdy_skid_buffer.sv
// Directed and randomized bench for val_rdy_skid_buffer. Inputs change and
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_val_rdy_skid_buffer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_val;
    logic         in_rdy;
    logic [W-1:0] in_msg;
    logic         out_val;
    logic         out_rdy;
    logic [W-1:0] out_msg;

    int passed = 0;
    int total  = 0;

    val_rdy_skid_buffer #(.p_nbits(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1; in_val = 1'b0; out_rdy = 1'b0; in_msg = '0;
        @(posedge clk);
        @(negedge clk);
        total++; if (in_rdy !== 1'b0) $display("FAIL reset_in_rdy: got %b want 0", in_rdy); else passed++;
        total++; if (out_val !== 1'b0) $display("FAIL reset_out_val: got %b want 0", out_val); else passed++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (in_rdy !== 1'b1) $display("FAIL post_reset_in_rdy: got %b want 1", in_rdy); else passed++;
        total++; if (out_val !== 1'b0) $display("FAIL post_reset_out_val: got %b want 0", out_val); else passed++;
    endtask

    task automatic test_single();
        in_val = 1'b1; in_msg = 32'hDEADBEEF; out_rdy = 1'b1;
        @(negedge clk);
        in_val = 1'b0;
        total++; if (out_val !== 1'b1) $display("FAIL single_out_val: got %b want 1", out_val); else passed++;
        total++; if (out_msg !== 32'hDEADBEEF) $display("FAIL single_out_msg: got %h want deadbeef", out_msg); else passed++;
        @(negedge clk);
        total++; if (out_val !== 1'b0) $display("FAIL single_empty: got out_val %b want 0", out_val); else passed++;
    endtask

    task automatic test_stream();
        out_rdy = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            if (c >= 1 && c <= 8) begin
                total++; if (out_val !== 1'b1 || out_msg !== W'(c))
                    $display("FAIL stream_out[%0d]: got val %b msg %h want val 1 msg %h", c, out_val, out_msg, c);
                else passed++;
            end
            if (c < 8) begin
                total++; if (in_rdy !== 1'b1) $display("FAIL stream_in_rdy[%0d]: got %b want 1", c, in_rdy); else passed++;
            end
            if (c == 9) begin
                total++; if (out_val !== 1'b0) $display("FAIL stream_drained: got out_val %b want 0", out_val); else passed++;
            end
            in_val = (c < 8);
            in_msg = W'(c + 1);
            @(negedge clk);
        end
        in_val = 1'b0;
    endtask

    task automatic test_skid();
        out_rdy = 1'b0; in_val = 1'b1; in_msg = 32'hA;
        #1;
        total++; if (in_rdy !== 1'b1) $display("FAIL skid_accept_a: got in_rdy %b want 1", in_rdy); else passed++;
        @(negedge clk);
        total++; if (in_rdy !== 1'b1 || out_val !== 1'b1 || out_msg !== 32'hA)
            $display("FAIL skid_one: got rdy %b val %b msg %h want 1 1 a", in_rdy, out_val, out_msg);
        else passed++;
        in_msg = 32'hB;
        @(negedge clk);
        total++; if (in_rdy !== 1'b0 || out_msg !== 32'hA)
            $display("FAIL skid_full: got rdy %b msg %h want 0 a", in_rdy, out_msg);
        else passed++;
        in_msg = 32'hC;
        @(negedge clk);
        total++; if (in_rdy !== 1'b0 || out_val !== 1'b1 || out_msg !== 32'hA)
            $display("FAIL skid_hold: got rdy %b val %b msg %h want 0 1 a", in_rdy, out_val, out_msg);
        else passed++;
        out_rdy = 1'b1;
        @(negedge clk);
        total++; if (in_rdy !== 1'b1 || out_val !== 1'b1 || out_msg !== 32'hB)
            $display("FAIL skid_drain_b: got rdy %b val %b msg %h want 1 1 b", in_rdy, out_val, out_msg);
        else passed++;
        @(negedge clk);
        in_val = 1'b0;
        total++; if (out_val !== 1'b1 || out_msg !== 32'hC)
            $display("FAIL skid_drain_c: got val %b msg %h want 1 c", out_val, out_msg);
        else passed++;
        @(negedge clk);
        total++; if (out_val !== 1'b0) $display("FAIL skid_empty: got out_val %b want 0", out_val); else passed++;
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b0; in_val = 1'b1; in_msg = 32'h11;
        @(negedge clk);
        in_msg = 32'h22;
        @(negedge clk);
        in_val = 1'b0;
        total++; if (in_rdy !== 1'b0 || out_msg !== 32'h11)
            $display("FAIL mid_full: got rdy %b msg %h want 0 11", in_rdy, out_msg);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++; if (out_val !== 1'b0 || in_rdy !== 1'b0)
            $display("FAIL mid_reset: got val %b rdy %b want 0 0", out_val, in_rdy);
        else passed++;
        reset = 1'b0; in_val = 1'b1; in_msg = 32'h33;
        @(negedge clk);
        in_val = 1'b0; out_rdy = 1'b1;
        total++; if (out_val !== 1'b1 || out_msg !== 32'h33)
            $display("FAIL mid_first_out: got val %b msg %h want 1 33", out_val, out_msg);
        else passed++;
        @(negedge clk);
        total++; if (out_val !== 1'b0) $display("FAIL mid_empty: got out_val %b want 0", out_val); else passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] model_q[$];
        logic [W-1:0] exp_msg;
        int  sent     = 0;
        int  received = 0;
        int  cycles   = 0;
        logic in_f    = 1'b0;
        in_val = 1'b0; out_rdy = 1'b0;
        while (received < 1000 && cycles < 20000) begin
            // Producer keeps a stalled message; otherwise picks fresh stimulus.
            if (!(in_val && !in_f)) begin
                in_val = (sent < 1000) && ($urandom_range(0, 1) == 1);
                in_msg = $urandom;
            end
            out_rdy = ($urandom_range(0, 1) == 1);
            #1;
            total++; if (in_rdy !== (model_q.size() < 2) || out_val !== (model_q.size() != 0))
                $display("FAIL rand_ctrl[%0d]: got rdy %b val %b want occupancy %0d", cycles, in_rdy, out_val, model_q.size());
            else passed++;
            if (out_val === 1'b1 && out_rdy && model_q.size() != 0) begin
                exp_msg = model_q.pop_front();
                total++; if (out_msg !== exp_msg)
                    $display("FAIL rand_msg[%0d]: got %h want %h", received, out_msg, exp_msg);
                else passed++;
                received++;
            end
            in_f = in_val && (in_rdy === 1'b1);
            if (in_f) begin
                model_q.push_back(in_msg);
                sent++;
            end
            cycles++;
            @(negedge clk);
        end
        in_val = 1'b0; out_rdy = 1'b0;
        total++; if (received != 1000) $display("FAIL rand_count: got %0d messages want 1000", received); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_skid();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
